// File: rtl/imem_port_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of a single-port,
// 1-read-latency on-chip RAM. At most one transfer is accepted per cycle.

module imem_port_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant,
    input  logic        rd_hit,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic [15:0] grant_cnt
);
    assign waitrequest   = ~grant;
    // a read accepted right before reset must not complete
    assign readdatavalid = rd_hit & ~reset;

    always_ff @(posedge clk) begin
        if (reset)
            grant_cnt <= '0;
        else if (grant && grant_cnt != 16'hFFFF)
            grant_cnt <= grant_cnt + 16'd1;
    end
endmodule

module imem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    output logic                ram_reset_req,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1
);
    localparam int BE_W  = DATA_W / 8;
    localparam int NUM_M = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
    } mreq_t;

    mreq_t [NUM_M-1:0]          mreq;
    mreq_t                      wreq;
    logic  [NUM_M-1:0]          req;
    logic  [NUM_M-1:0]          grant;
    logic  [NUM_M-1:0]          rd_hit;
    logic  [NUM_M-1:0]          waitreq;
    logic  [NUM_M-1:0]          rdvalid;
    logic  [NUM_M-1:0][15:0]    cnt;
    logic                       granted;
    logic                       win;
    logic                       rr_ptr;
    logic                       rd_pend;
    logic                       rd_id;
    logic  [ADDR_W-1:0]         last_addr_q;

    assign mreq[0] = '{m0_address, m0_byteenable, m0_read, m0_write, m0_writedata};
    assign mreq[1] = '{m1_address, m1_byteenable, m1_read, m1_write, m1_writedata};

    always_comb begin
        for (int n = 0; n < NUM_M; n++)
            req[n] = mreq[n].read | mreq[n].write;
    end

    // rr_ptr only matters when both masters contend
    always_comb begin
        grant = '0;
        if (!reset && !freeze) begin
            if (req[0] && (!req[1] || !rr_ptr))
                grant[0] = 1'b1;
            else if (req[1])
                grant[1] = 1'b1;
        end
    end

    assign granted = |grant;
    assign win     = grant[1];
    assign wreq    = mreq[win];

    assign ram_chipselect = granted;
    assign ram_write      = granted & wreq.write;
    assign ram_address    = granted ? wreq.address : last_addr_q;
    assign ram_byteenable = (granted && wreq.write) ? wreq.byteenable : '1;
    assign ram_writedata  = wreq.writedata;
    assign ram_clken      = ~freeze;
    assign ram_reset_req  = reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            rd_pend     <= 1'b0;
            rd_id       <= 1'b0;
            last_addr_q <= '0;
        end else begin
            // read+write together is a write: no response expected
            rd_pend <= granted & wreq.read & ~wreq.write;
            if (granted) begin
                rr_ptr      <= ~win;
                rd_id       <= win;
                last_addr_q <= wreq.address;
            end
        end
    end

    assign rd_hit[0] = rd_pend & ~rd_id;
    assign rd_hit[1] = rd_pend & rd_id;

    imem_port_lane u_lane [NUM_M-1:0] (
        .clk           (clk),
        .reset         (reset),
        .grant         (grant),
        .rd_hit        (rd_hit),
        .waitrequest   (waitreq),
        .readdatavalid (rdvalid),
        .grant_cnt     (cnt)
    );

    assign m0_waitrequest   = waitreq[0];
    assign m1_waitrequest   = waitreq[1];
    assign m0_readdatavalid = rdvalid[0];
    assign m1_readdatavalid = rdvalid[1];
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign grant_cnt0       = cnt[0];
    assign grant_cnt1       = cnt[1];
endmodule
